// File: rtl/wb_regfile_if.sv
// wb_regfile_if: bundle of the MEM/WB write-back, ID read and debug signals of wb_regfile.
//   master : pipeline side; drives write-back data/controls, read and debug indices.
//   slave  : register file side; returns read data, debug data, selected write-back
//            value and the committed-write count.
interface wb_regfile_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
);
    logic [DATA_WIDTH-1:0]     alu_result_in;
    logic [DATA_WIDTH-1:0]     read_data_in;
    logic [REG_ADDR_WIDTH-1:0] write_register_in;
    logic                      reg_write_in;
    logic                      mem_to_reg_in;
    logic [DATA_WIDTH-1:0]     pc_plus_4_in;
    logic                      is_jal_in;
    logic [REG_ADDR_WIDTH-1:0] read_register_1;
    logic [REG_ADDR_WIDTH-1:0] read_register_2;
    logic [REG_ADDR_WIDTH-1:0] debug_addr;
    logic [DATA_WIDTH-1:0]     read_data_1;
    logic [DATA_WIDTH-1:0]     read_data_2;
    logic [DATA_WIDTH-1:0]     debug_data;
    logic [DATA_WIDTH-1:0]     wb_data_out;
    logic [31:0]               wb_write_count;

    modport master (
        output alu_result_in, read_data_in, write_register_in, reg_write_in, mem_to_reg_in,
               pc_plus_4_in, is_jal_in, read_register_1, read_register_2, debug_addr,
        input  read_data_1, read_data_2, debug_data, wb_data_out, wb_write_count
    );

    modport slave (
        input  alu_result_in, read_data_in, write_register_in, reg_write_in, mem_to_reg_in,
               pc_plus_4_in, is_jal_in, read_register_1, read_register_2, debug_addr,
        output read_data_1, read_data_2, debug_data, wb_data_out, wb_write_count
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage plus general-purpose register file.
//   clk   : single clock, rising-edge state updates.
//   reset : synchronous active-high; clears all entries and the write counter.
//   bus   : wb_regfile_if slave port
//           - write-back select (jal link > load data > ALU result) -> wb_data_out
//           - two combinational read ports with write-before-read bypass
//           - debug read port showing stored contents only
//           - wb_write_count: number of committed writes, wraps silently
module wb_regfile #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    localparam int unsigned NumRegs = 2 ** REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];
    logic [DATA_WIDTH-1:0] regs_d [NumRegs];
    logic [31:0]           write_count_q;
    logic [31:0]           write_count_d;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  commit;

    always_comb begin
        if (bus.is_jal_in) begin
            wb_data = bus.pc_plus_4_in;
        end else if (bus.mem_to_reg_in) begin
            wb_data = bus.read_data_in;
        end else begin
            wb_data = bus.alu_result_in;
        end
    end

    // Writes to r0 are dropped here, so r0 never leaves its reset value.
    assign commit = !reset && bus.reg_write_in && (bus.write_register_in != '0);

    always_comb begin
        regs_d        = regs_q;
        write_count_d = write_count_q;
        if (commit) begin
            regs_d[bus.write_register_in] = wb_data;
            write_count_d                 = write_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q        <= '{default: '0};
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end

    // Read ports: r0 is hard zero; otherwise a same-cycle commit to the index wins.
    always_comb begin
        bus.read_data_1 = regs_q[bus.read_register_1];
        if (commit && (bus.read_register_1 == bus.write_register_in)) begin
            bus.read_data_1 = wb_data;
        end
        if (bus.read_register_1 == '0) begin
            bus.read_data_1 = '0;
        end

        bus.read_data_2 = regs_q[bus.read_register_2];
        if (commit && (bus.read_register_2 == bus.write_register_in)) begin
            bus.read_data_2 = wb_data;
        end
        if (bus.read_register_2 == '0) begin
            bus.read_data_2 = '0;
        end

        bus.debug_data = (bus.debug_addr == '0) ? '0 : regs_q[bus.debug_addr];
    end

    assign bus.wb_data_out    = wb_data;
    assign bus.wb_write_count = write_count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed stimulus against wb_regfile with an array-based reference model
// checked every cycle on the falling edge, plus literal expectations for key scenarios.
module tb_wb_regfile;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_regfile_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

    wb_regfile #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state.
    logic [31:0] m_regs [32];
    logic [31:0] m_count;
    logic        model_valid = 1'b0;
    logic        bd_load = 1'b0;
    logic [31:0] bd_val = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_wb();
        if (bus.is_jal_in) return bus.pc_plus_4_in;
        if (bus.mem_to_reg_in) return bus.read_data_in;
        return bus.alu_result_in;
    endfunction

    function automatic logic m_commit();
        return !reset && bus.reg_write_in && (bus.write_register_in != 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx, input logic bypass);
        if (idx == 5'd0) return 32'd0;
        if (bypass && m_commit() && idx == bus.write_register_in) return exp_wb();
        return m_regs[idx];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
            m_count     <= 32'd0;
            model_valid <= 1'b1;
        end else begin
            if (m_commit()) m_regs[bus.write_register_in] <= exp_wb();
            m_count <= (bd_load ? bd_val : m_count) + (m_commit() ? 32'd1 : 32'd0);
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("cyc_wb_data", bus.wb_data_out, exp_wb());
            check("cyc_rd1", bus.read_data_1, exp_read(bus.read_register_1, 1'b1));
            check("cyc_rd2", bus.read_data_2, exp_read(bus.read_register_2, 1'b1));
            check("cyc_debug", bus.debug_data, exp_read(bus.debug_addr, 1'b0));
            check("cyc_count", bus.wb_write_count, bd_load ? bd_val : m_count);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic we, input logic [4:0] wa, input logic [31:0] alu);
        bus.reg_write_in      = we;
        bus.write_register_in = wa;
        bus.alu_result_in     = alu;
        bus.mem_to_reg_in     = 1'b0;
        bus.is_jal_in         = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] dbg);
        bus.read_register_1 = a1;
        bus.read_register_2 = a2;
        bus.debug_addr      = dbg;
    endtask

    initial begin
        bus.read_data_in = '0;
        bus.pc_plus_4_in = '0;
        wr(1'b1, 5'd5, 32'h0000_0077);
        rd(5'd0, 5'd0, 5'd0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        wr(1'b0, 5'd0, 32'd0);
        rd(5'd5, 5'd5, 5'd5);
        #1;
        check("post_reset_rd1", bus.read_data_1, 32'd0);
        check("post_reset_count", bus.wb_write_count, 32'd0);

        // ALU-path write to r5, then read it back.
        wr(1'b1, 5'd5, 32'h1234_5678);
        step();
        wr(1'b0, 5'd0, 32'd0);
        #1;
        check("r5_rd1", bus.read_data_1, 32'h1234_5678);
        check("r5_count", bus.wb_write_count, 32'd1);

        // Write-back select priority.
        bus.alu_result_in = 32'hA;
        bus.read_data_in  = 32'hB;
        bus.pc_plus_4_in  = 32'hC;
        bus.is_jal_in     = 1'b1;
        bus.mem_to_reg_in = 1'b1;
        #1;
        check("sel_jal", bus.wb_data_out, 32'hC);
        bus.is_jal_in = 1'b0;
        #1;
        check("sel_mem", bus.wb_data_out, 32'hB);
        bus.mem_to_reg_in = 1'b0;
        #1;
        check("sel_alu", bus.wb_data_out, 32'hA);
        step();

        // Dual-port bypass; debug port shows the old value.
        wr(1'b1, 5'd7, 32'hDEAD_BEEF);
        rd(5'd7, 5'd7, 5'd7);
        #1;
        check("byp_rd1", bus.read_data_1, 32'hDEAD_BEEF);
        check("byp_rd2", bus.read_data_2, 32'hDEAD_BEEF);
        check("byp_debug_old", bus.debug_data, 32'd0);
        step();
        wr(1'b0, 5'd0, 32'd0);
        #1;
        check("byp_debug_new", bus.debug_data, 32'hDEAD_BEEF);

        // Write to r0 is discarded, even during the commit cycle.
        wr(1'b1, 5'd0, 32'hFFFF_FFFF);
        rd(5'd0, 5'd0, 5'd0);
        #1;
        check("r0_rd1", bus.read_data_1, 32'd0);
        check("r0_rd2", bus.read_data_2, 32'd0);
        step();
        wr(1'b0, 5'd0, 32'd0);
        #1;
        check("r0_debug", bus.debug_data, 32'd0);
        check("r0_count", bus.wb_write_count, 32'd2);

        // Back-to-back writes to r9.
        wr(1'b1, 5'd9, 32'h1);
        rd(5'd9, 5'd5, 5'd9);
        #1;
        check("b2b_first", bus.read_data_1, 32'h1);
        step();
        wr(1'b1, 5'd9, 32'h2);
        #1;
        check("b2b_second", bus.read_data_1, 32'h2);
        check("b2b_debug", bus.debug_data, 32'h1);
        step();
        wr(1'b0, 5'd0, 32'd0);
        #1;
        check("b2b_final", bus.read_data_1, 32'h2);
        check("b2b_count", bus.wb_write_count, 32'd4);

        // Reset mid-operation while a write to r3 is presented.
        wr(1'b1, 5'd3, 32'h55);
        step();
        check("r3_count", bus.wb_write_count, 32'd5);
        reset = 1'b1;
        wr(1'b1, 5'd3, 32'h99);
        rd(5'd3, 5'd5, 5'd3);
        #1;
        check("rst_no_bypass", bus.read_data_1, 32'h55);
        step();
        reset = 1'b0;
        wr(1'b0, 5'd0, 32'd0);
        #1;
        check("rst_r3", bus.read_data_1, 32'd0);
        check("rst_r5", bus.read_data_2, 32'd0);
        check("rst_count", bus.wb_write_count, 32'd0);

        // Counter wrap via backdoor preload.
        force dut.write_count_q = 32'hFFFF_FFFF;
        release dut.write_count_q;
        bd_val  = 32'hFFFF_FFFF;
        bd_load = 1'b1;
        #1;
        check("preload_count", bus.wb_write_count, 32'hFFFF_FFFF);
        step();
        bd_load = 1'b0;
        wr(1'b1, 5'd4, 32'h7);
        rd(5'd4, 5'd4, 5'd4);
        #1;
        check("wrap_before", bus.wb_write_count, 32'hFFFF_FFFF);
        step();
        wr(1'b0, 5'd0, 32'd0);
        #1;
        check("wrap_count", bus.wb_write_count, 32'd0);
        check("wrap_r4", bus.read_data_1, 32'h7);

        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
